// File: rtl/hhmm_level_ctrl.sv
// Parent-side HHMM level controller: drives child BV commands, picks the entered child, reports termination upward.
// Latency: every output is registered; a change shows one cycle after the edge that samples its cause.
// Backpressure: none; BV_in=2 freezes the active child in place, BV_in=0 aborts to IDLE.
module hhmm_level_ctrl #(
    parameter int NCHILD    = 4,
    parameter int INIT_CYC  = 2,
    parameter int ENTER_MAX = 8,
    parameter int CW        = 8
) (
    input  logic                  CLK,
    input  logic                  INIT,
    input  logic [1:0]            BV_in,
    input  logic [NCHILD-1:0]     P_ent,
    input  logic [NCHILD-1:0]     T_child,
    output logic [2*NCHILD-1:0]   BV_out,
    output logic [NCHILD-1:0]     S,
    output logic                  T_out,
    output logic [CW-1:0]         term_cnt
);
    localparam int AW = (NCHILD > 1) ? $clog2(NCHILD) : 1;

    typedef enum logic [2:0] {IDLE, CINIT, ENTER, ACTIVE, TERM} state_t;

    state_t        state;
    logic [3:0]    icnt;
    logic [7:0]    wcnt;
    logic [AW-1:0] act;
    logic [AW-1:0] first_idx;

    // Lowest set entry bit wins when several children request entry together.
    always_comb begin
        first_idx = '0;
        for (int i = NCHILD - 1; i >= 0; i--) begin
            if (P_ent[i]) first_idx = AW'(i);
        end
    end

    function automatic logic [2*NCHILD-1:0] one_cmd(input logic [AW-1:0] idx, input logic [1:0] cmd);
        logic [2*NCHILD-1:0] v;
        v = '0;
        for (int i = 0; i < NCHILD; i++) begin
            if (idx == AW'(i)) v[2*i +: 2] = cmd;
        end
        return v;
    endfunction

    always_ff @(posedge CLK) begin
        if (INIT) begin
            state    <= IDLE;
            icnt     <= '0;
            wcnt     <= '0;
            act      <= '0;
            BV_out   <= '0;
            S        <= '0;
            T_out    <= 1'b0;
            term_cnt <= '0;
        end else begin
            T_out <= 1'b0;
            case (state)
                IDLE: begin
                    BV_out <= '0;
                    S      <= '0;
                    if (BV_in == 2'd3) begin
                        state  <= CINIT;
                        icnt   <= 4'd1;
                        BV_out <= '1;
                    end else if (BV_in == 2'd1) begin
                        state <= ENTER;
                        wcnt  <= '0;
                    end
                end
                CINIT, TERM: begin
                    // Hold BV=3 until the child latches have seen INIT_CYC cycles of it.
                    if (icnt == 4'(INIT_CYC)) begin
                        state  <= IDLE;
                        BV_out <= '0;
                    end else begin
                        icnt <= icnt + 4'd1;
                    end
                end
                ENTER: begin
                    if (BV_in == 2'd0) begin
                        state <= IDLE;
                    end else if (|P_ent) begin
                        state  <= ACTIVE;
                        act    <= first_idx;
                        S      <= NCHILD'(1) << first_idx;
                        BV_out <= one_cmd(first_idx, 2'd1);
                    end else if (wcnt == 8'(ENTER_MAX - 1)) begin
                        state  <= ACTIVE;
                        act    <= '0;
                        S      <= NCHILD'(1);
                        BV_out <= one_cmd('0, 2'd1);
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                ACTIVE: begin
                    case (BV_in)
                        2'd0: begin
                            state  <= IDLE;
                            S      <= '0;
                            BV_out <= '0;
                        end
                        2'd3: begin
                            state  <= CINIT;
                            icnt   <= 4'd1;
                            S      <= '0;
                            BV_out <= '1;
                        end
                        2'd2: BV_out <= one_cmd(act, 2'd2);
                        default: begin
                            if (T_child[act]) begin
                                state  <= TERM;
                                icnt   <= 4'd1;
                                T_out  <= 1'b1;
                                S      <= '0;
                                BV_out <= one_cmd(act, 2'd3);
                                if (term_cnt != '1) term_cnt <= term_cnt + CW'(1);
                            end else begin
                                BV_out <= one_cmd(act, 2'd1);
                            end
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/hhmm_level_ctrl.md
Name: hhmm_level_ctrl

Overview:
- Parent-side driver of the HHMM level command/termination interface: issues the 2-bit BV command to NCHILD child levels and consumes their T termination flags.
- Selects the entered child from stochastic entry bits.
- Re-initialises a child after it terminates and reports termination upward to its own parent.
- Sits between a higher HHMM level, which drives BV_in, and a bank of child level modules.

Parameters:
- NCHILD, 4: number of child levels (2..8).
- INIT_CYC, 2: cycles BV=3 is held on an init or re-init (1..15).
- ENTER_MAX, 8: cycles to wait for a stochastic entry bit before forcing child 0 (1..255).
- CW, 8: width of the saturating termination counter.

Ports:
- CLK  in  1  rising-edge clock.
- INIT  in  1  synchronous active-high reset.
- BV_in  in  2  command from parent: 0 sleep, 1 search, 2 sub-state active (freeze), 3 initialise.
- P_ent  in  NCHILD  stochastic entry bit per child, sampled each cycle.
- T_child  in  NCHILD  termination flag from each child; stays high until that child receives BV=3.
- BV_out  out  2*NCHILD  command to child i on bits [2i+1:2i].
- S  out  NCHILD  one-hot active child, or all zero.
- T_out  out  1  one-cycle pulse when the active child terminates.
- term_cnt  out  CW  count of completed child terminations, saturating.

Behaviour:
- All outputs are registered. A state change is visible on the outputs one cycle after the edge that samples its cause.
- INIT=1 at an edge:
  - state goes to IDLE;
  - BV_out=0, S=0, T_out=0, term_cnt=0;
  - internal counters clear.
  - INIT overrides every other input, including mid-operation.
- IDLE:
  - all BV_out=0.
  - BV_in=3 -> CINIT. BV_in=1 -> ENTER. Otherwise stay.
- CINIT:
  - every child gets BV=3 for exactly INIT_CYC cycles; S=0.
  - then -> IDLE.
  - CINIT is not abortable by BV_in. Only INIT aborts it.
- ENTER:
  - all BV_out=0. Wait counter increments each cycle.
  - If any P_ent bit is 1: select the lowest index i with P_ent[i]=1, set S=one-hot(i), -> ACTIVE.
  - If no bit is set for ENTER_MAX consecutive cycles: select child 0, -> ACTIVE.
  - BV_in=0 -> IDLE.
- ACTIVE (child a = index of S):
  - BV_out[a]=1; all other children get 0.
  - T_child[a]=1 and BV_in=1 -> TERM; term_cnt increments unless it is all-ones.
  - T_child bits of inactive children are ignored.
  - BV_in=2: freeze. BV_out[a]=2, S held, T_child ignored, no transition.
  - BV_in=0: abort. -> IDLE, S=0, all BV_out=0, no T_out, no count.
  - BV_in=3: -> CINIT.
- TERM:
  - T_out=1 on the first TERM cycle only.
  - BV_out[a]=3 for INIT_CYC cycles to clear the child's latched T; others get 0.
  - S=0 from the first TERM cycle.
  - then -> IDLE.
  - BV_in is ignored during TERM.
- Simultaneous events:
  - T_child[a] rising in the same cycle BV_in goes to 0 or 3: the abort or init wins; no T_out pulse, no count.
  - Several P_ent bits set together: lowest index wins.
- T_out is never high for two consecutive cycles.
- S is all zero in every state except ACTIVE.

Test Plan:
- Reset and init: INIT=1 for 2 cycles, then BV_in=3 for 1 cycle with NCHILD=4, INIT_CYC=2 -> BV_out=8'hFF for exactly 2 cycles, then 8'h00; S=0; term_cnt=0.
- Entry priority: BV_in=1, P_ent=4'b0110 on the first ENTER cycle -> S=4'b0010, BV_out=8'h04 next cycle.
- Entry timeout: BV_in=1, P_ent=0 held, ENTER_MAX=8 -> after 8 ENTER cycles S=4'b0001, BV_out=8'h01.
- Termination: in ACTIVE with a=2, raise T_child[2] -> T_out pulses 1 cycle; BV_out=8'h30 for 2 cycles; term_cnt=1; S=0; returns to IDLE with BV_out=0.
- Freeze, abort and simultaneous events:
  - ACTIVE with a=1, BV_in=2 and T_child[1]=1 -> BV_out=8'h08, S held, no T_out.
  - Then BV_in=0 in the same cycle as T_child[1] -> IDLE, no pulse, term_cnt unchanged.
- Saturation and reset mid-operation:
  - CW=2: 5 full enter/terminate rounds -> term_cnt stays at 3.
  - INIT asserted during TERM -> all outputs 0 next cycle.
